// File: rtl/io_port_bridge.sv
// Memory-mapped I/O responder for the single-cycle CPU: commits bus writes once per
// CPU cycle, serves combinational reads, and conditions switches and keys.
module io_port_bridge #(
    parameter logic [23:0] BASE_ADDR       = 24'h000000,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          NKEY            = 4
) (
    input  logic            main_clk,
    input  logic            resetn,
    input  logic            cpu_clk,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic            we,
    output logic [31:0]     rdata,
    input  logic [9:0]      sw,
    input  logic [NKEY-1:0] key_n,
    output logic [31:0]     out_port0,
    output logic [31:0]     out_port1
);

    localparam logic [7:0]  OFF_SW     = 8'hC0;
    localparam logic [7:0]  OFF_KEY    = 8'hC4;
    localparam logic [7:0]  OFF_EVT    = 8'hC8;
    localparam logic [7:0]  OFF_PORT0  = 8'hCC;
    localparam logic [7:0]  OFF_PORT1  = 8'hD0;
    localparam logic [7:0]  OFF_CYC    = 8'hD4;
    localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);

    logic            commit;
    logic            hit;
    logic            wr;
    logic [7:0]      offs;
    logic [9:0]      sw_p0, sw_p1;
    logic [NKEY-1:0] key_p0, key_p1;
    logic [NKEY-1:0] stable;
    logic [NKEY-1:0] evt;
    logic [NKEY-1:0] accept;
    logic [NKEY-1:0] evt_clr;
    logic [15:0]     cnt [NKEY];
    logic [31:0]     cyc;

    // cpu_clk low at this edge means this is the final main_clk edge of the CPU cycle
    assign commit = ~cpu_clk;
    assign hit    = (addr[31:8] == BASE_ADDR);
    assign offs   = addr[7:0];
    assign wr     = commit & we & hit;

    // Stage p0/p1: two-flop synchronisers; keys are inverted so 1 means pressed
    always_ff @(posedge main_clk or negedge resetn) begin
        if (!resetn) begin
            sw_p0  <= '0;
            sw_p1  <= '0;
            key_p0 <= '0;
            key_p1 <= '0;
        end else begin
            sw_p0  <= sw;
            sw_p1  <= sw_p0;
            key_p0 <= ~key_n;
            key_p1 <= key_p0;
        end
    end

    always_comb begin
        accept  = '0;
        evt_clr = '0;
        for (int i = 0; i < NKEY; i++) begin
            accept[i] = key_p1[i] & ~stable[i] & (cnt[i] == DB_LAST);
        end
        if (wr && offs == OFF_EVT) begin
            evt_clr = wdata[NKEY-1:0];
        end
    end

    // Debounce stage: a new level must persist DEBOUNCE_CYCLES edges before acceptance
    always_ff @(posedge main_clk or negedge resetn) begin
        if (!resetn) begin
            stable <= '0;
            evt    <= '0;
            for (int i = 0; i < NKEY; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NKEY; i++) begin
                if (key_p1[i] != stable[i]) begin
                    if (cnt[i] == DB_LAST) begin
                        stable[i] <= key_p1[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 16'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
            // A press accepted on the same edge as a clear keeps the event set
            evt <= (evt & ~evt_clr) | accept;
        end
    end

    always_ff @(posedge main_clk or negedge resetn) begin
        if (!resetn) begin
            out_port0 <= '0;
            out_port1 <= '0;
            cyc       <= '0;
        end else begin
            if (commit) begin
                cyc <= cyc + 32'd1;
            end
            if (wr && offs == OFF_PORT0) begin
                out_port0 <= wdata;
            end
            if (wr && offs == OFF_PORT1) begin
                out_port1 <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (offs)
                OFF_SW:    rdata = {22'b0, sw_p1};
                OFF_KEY:   rdata = 32'(stable);
                OFF_EVT:   rdata = 32'(evt);
                OFF_PORT0: rdata = out_port0;
                OFF_PORT1: rdata = out_port1;
                OFF_CYC:   rdata = cyc;
                default:   rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed plus randomized checks of io_port_bridge against an edge-level behavioural
// model built from the register map and debounce rules.
module tb_io_port_bridge;

    localparam int NKEY = 4;
    localparam int DB   = 4;

    logic            main_clk = 1'b0;
    logic            resetn;
    logic            cpu_clk;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic            we;
    logic [31:0]     rdata;
    logic [9:0]      sw;
    logic [NKEY-1:0] key_n;
    logic [31:0]     out_port0;
    logic [31:0]     out_port1;

    int errors   = 0;
    int checks   = 0;
    int cpu_mode = 0;  // 0 toggling, 1 stuck high, 2 stuck low

    logic [9:0]      m_sw0, m_sw1;
    logic [NKEY-1:0] m_k0, m_k1, m_stable, m_evt;
    int              m_run [NKEY];
    logic [31:0]     m_out0, m_out1, m_cyc;

    io_port_bridge #(
        .BASE_ADDR      (24'h000000),
        .DEBOUNCE_CYCLES(DB),
        .NKEY           (NKEY)
    ) dut (
        .main_clk (main_clk),
        .resetn   (resetn),
        .cpu_clk  (cpu_clk),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .rdata    (rdata),
        .sw       (sw),
        .key_n    (key_n),
        .out_port0(out_port0),
        .out_port1(out_port1)
    );

    always #10 main_clk = ~main_clk;

    task automatic m_reset();
        m_sw0 = '0; m_sw1 = '0; m_k0 = '0; m_k1 = '0;
        m_stable = '0; m_evt = '0;
        m_out0 = '0; m_out1 = '0; m_cyc = '0;
        for (int i = 0; i < NKEY; i++) m_run[i] = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:8] != 24'h0) return 32'h0;
        case (a[7:0])
            8'hC0:   return {22'b0, m_sw1};
            8'hC4:   return 32'(m_stable);
            8'hC8:   return 32'(m_evt);
            8'hCC:   return m_out0;
            8'hD0:   return m_out1;
            8'hD4:   return m_cyc;
            default: return 32'h0;
        endcase
    endfunction

    // Apply one main_clk edge to the model, given the inputs seen at that edge
    task automatic m_edge(input logic c_cpu, input logic c_we, input logic [31:0] c_addr,
                          input logic [31:0] c_wdata, input logic [9:0] c_sw,
                          input logic [NKEY-1:0] c_kn);
        logic commit, wr, rose;
        commit = !c_cpu;
        wr = commit && c_we && (c_addr[31:8] == 24'h0);
        for (int i = 0; i < NKEY; i++) begin
            rose = 1'b0;
            if (m_k1[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_stable[i] = m_k1[i];
                    m_run[i] = 0;
                    rose = m_stable[i];
                end
            end else begin
                m_run[i] = 0;
            end
            if (rose) m_evt[i] = 1'b1;
            else if (wr && c_addr[7:0] == 8'hC8 && c_wdata[i]) m_evt[i] = 1'b0;
        end
        m_k1 = m_k0; m_k0 = ~c_kn;
        m_sw1 = m_sw0; m_sw0 = c_sw;
        if (wr && c_addr[7:0] == 8'hCC) m_out0 = c_wdata;
        if (wr && c_addr[7:0] == 8'hD0) m_out1 = c_wdata;
        if (commit) m_cyc = m_cyc + 32'd1;
    endtask

    task automatic tick();
        logic c_cpu, c_we, c_rst;
        logic [31:0] c_addr, c_wdata;
        logic [9:0] c_sw;
        logic [NKEY-1:0] c_kn;
        c_cpu = cpu_clk; c_we = we; c_rst = resetn; c_addr = addr;
        c_wdata = wdata; c_sw = sw; c_kn = key_n;
        @(posedge main_clk);
        if (c_rst && resetn) m_edge(c_cpu, c_we, c_addr, c_wdata, c_sw, c_kn);
        #1;
        if (cpu_mode == 0)      cpu_clk = ~cpu_clk;
        else if (cpu_mode == 1) cpu_clk = 1'b1;
        else                    cpu_clk = 1'b0;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a);
        addr = a;
        we = 1'b0;
        #1;
        chk(tag, rdata, m_read(a));
    endtask

    task automatic chk_ports(input string tag);
        chk({tag, "_port0"}, out_port0, m_out0);
        chk({tag, "_port1"}, out_port1, m_out1);
    endtask

    // Leave cpu_clk high so the next two edges form exactly one CPU cycle
    task automatic align();
        for (int i = 0; i < 3 && cpu_clk !== 1'b1; i++) tick();
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        align();
        addr = a; wdata = d; we = 1'b1;
        tick();
        tick();
        we = 1'b0;
    endtask

    logic [31:0] saved;
    logic [31:0] addr_pool [8];

    initial begin
        addr_pool[0] = 32'hC0; addr_pool[1] = 32'hC4; addr_pool[2] = 32'hC8;
        addr_pool[3] = 32'hCC; addr_pool[4] = 32'hD0; addr_pool[5] = 32'hD4;
        addr_pool[6] = 32'hE0; addr_pool[7] = 32'h100000CC;

        resetn = 1'b0; cpu_clk = 1'b1; addr = '0; wdata = '0; we = 1'b0;
        sw = '0; key_n = '1;
        m_reset();
        repeat (3) tick();
        chk_ports("reset");
        rd_chk("reset_cyc", 32'hD4);
        rd_chk("reset_evt", 32'hC8);
        resetn = 1'b1;

        // Single write: one commit, out_port1 untouched
        align();
        saved = m_cyc;
        addr = 32'hCC; wdata = 32'hDEADBEEF; we = 1'b1;
        tick();
        chk_ports("write_mid");
        tick();
        we = 1'b0;
        chk("write_port0", out_port0, 32'hDEADBEEF);
        chk_ports("write_done");
        rd_chk("write_cyc", 32'hD4);
        chk("write_one_commit", rdata, saved + 32'd1);

        // Asynchronous reset mid-cycle, key 2 held throughout
        key_n[2] = 1'b0;
        cpu_write(32'hCC, 32'h5);
        chk("pre_reset_port0", out_port0, 32'h5);
        #3;
        resetn = 1'b0;
        m_reset();
        #1;
        chk("async_reset_port0", out_port0, 32'h0);
        rd_chk("async_reset_rd_cc", 32'hCC);
        repeat (2) tick();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            rd_chk("post_reset_cyc", 32'hD4);
        end
        rd_chk("held_key_stable", 32'hC4);
        rd_chk("held_key_evt", 32'hC8);
        chk("held_key_evt_val", rdata, 32'h4);

        key_n[2] = 1'b1;
        cpu_write(32'hC8, 32'hF);
        rd_chk("evt_cleared", 32'hC8);

        // Switch synchroniser latency
        sw = 10'h2AA;
        tick();
        rd_chk("sw_1edge", 32'hC0);
        tick();
        rd_chk("sw_2edge", 32'hC0);
        chk("sw_value", rdata, 32'h2AA);

        // Debounce: a 3-edge glitch is rejected
        repeat (8) tick();
        key_n[0] = 1'b0;
        repeat (3) tick();
        key_n[0] = 1'b1;
        repeat (8) tick();
        rd_chk("glitch_stable", 32'hC4);
        chk("glitch_stable0", {31'b0, rdata[0]}, 32'h0);
        rd_chk("glitch_evt", 32'hC8);
        chk("glitch_evt_val", rdata, 32'h0);

        // Debounce: held press accepted after 2+DB edges
        key_n[0] = 1'b0;
        repeat (5) tick();
        rd_chk("press_5edges", 32'hC4);
        chk("press_5edges_bit", {31'b0, rdata[0]}, 32'h0);
        tick();
        rd_chk("press_6edges", 32'hC4);
        chk("press_6edges_bit", {31'b0, rdata[0]}, 32'h1);
        rd_chk("press_evt", 32'hC8);
        chk("press_evt_val", rdata, 32'h1);

        // W1C race with cpu_clk stuck low (commit on every edge)
        cpu_mode = 2; cpu_clk = 1'b0;
        key_n[1] = 1'b0;
        repeat (6) tick();
        rd_chk("k1_press_evt", 32'hC8);
        key_n[1] = 1'b1;
        repeat (6) tick();
        rd_chk("k1_release_stable", 32'hC4);
        rd_chk("k1_release_evt", 32'hC8);
        key_n[1] = 1'b0;
        repeat (5) tick();
        addr = 32'hC8; wdata = 32'h2; we = 1'b1;
        tick();
        rd_chk("race_set_wins", 32'hC8);
        chk("race_set_wins_bit", {31'b0, rdata[1]}, 32'h1);
        addr = 32'hC8; wdata = 32'h2; we = 1'b1;
        tick();
        rd_chk("w1c_later", 32'hC8);
        chk("w1c_later_bit", {31'b0, rdata[1]}, 32'h0);
        rd_chk("stuck_low_cyc", 32'hD4);

        // cpu_clk stuck high: no commits
        cpu_mode = 1; cpu_clk = 1'b1;
        saved = m_cyc;
        addr = 32'hD0; wdata = 32'h12345678; we = 1'b1;
        repeat (4) tick();
        chk_ports("stuck_high");
        rd_chk("stuck_high_cyc", 32'hD4);
        chk("stuck_high_no_commit", rdata, saved);
        cpu_mode = 0;
        cpu_write(32'hD0, 32'h12345678);
        chk("port1_write", out_port1, 32'h12345678);

        // Decode: miss writes ignored, unmapped offset reads 0
        saved = out_port0;
        cpu_write(32'h100000CC, 32'hFFFF0000);
        chk("miss_write_ignored", out_port0, saved);
        chk_ports("miss_write");
        rd_chk("unmapped_read", 32'hE0);
        rd_chk("miss_read", 32'h100000D4);

        // Cycle counter wrap
        align();
        force dut.cyc = 32'hFFFFFFFF;
        #1;
        release dut.cyc;
        m_cyc = 32'hFFFFFFFF;
        rd_chk("cyc_forced", 32'hD4);
        tick();
        tick();
        rd_chk("cyc_wrap", 32'hD4);
        chk("cyc_wrap_zero", rdata, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (cpu_clk == 1'b1) begin
                addr  = addr_pool[$urandom_range(0, 7)];
                wdata = $urandom;
                we    = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 15) == 0) sw = 10'($urandom);
            for (int k = 0; k < NKEY; k++) begin
                if ($urandom_range(0, 7) == 0) key_n[k] = ~key_n[k];
            end
            tick();
            chk_ports("rand");
            chk("rand_rdata", rdata, m_read(addr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Memory-mapped I/O responder for the single-cycle CPU, clocked by the fast main clock that also drives the memories.
- Accepts CPU bus writes, which are stable for a whole CPU clock period, and commits them exactly once per CPU cycle by sampling the divided CPU clock as data.
- Serves CPU reads combinationally.
- Synchronises and debounces board switches and keys, latches key-press events, and drives two output ports (LEDs / seven-segment).

Parameters:
- BASE_ADDR, 24'h000000: required value of addr[31:8] for a hit.
- DEBOUNCE_CYCLES, 50000: main_clk cycles a synchronised key must hold a new level before it is accepted; legal range 2..65535.
- NKEY, 4: number of keys.

Ports:
- main_clk  in  1  main clock; all flops on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cpu_clk  in  1  divided CPU clock (main_clk/2); sampled as data only, never used as a clock.
- addr  in  32  CPU byte address.
- wdata  in  32  CPU write data.
- we  in  1  CPU write enable.
- rdata  out  32  read data, combinational.
- sw  in  10  raw switches, asynchronous.
- key_n  in  NKEY  raw keys, asynchronous, active-low.
- out_port0  out  32  LED register.
- out_port1  out  32  seven-segment register.

Behaviour:
- **Hit decode:** hit = (addr[31:8]==BASE_ADDR). Offsets are addr[7:0]; any other offset reads 0 and ignores writes.
- **Commit strobe:** commit is true on a main_clk edge where the sampled cpu_clk is 0, i.e. the last main_clk edge of each CPU cycle.
  - Exactly one commit per CPU cycle.
  - Register writes occur only when commit && we && hit.
- **Switch path:** sw passes through a 2-flop synchroniser giving sw_s (latency 2 edges). No debounce.
- **Key path, per key:**
  - Invert key_n, then pass through a 2-flop synchroniser, then the debounce counter cnt (16 bits).
  - If synced != stable: cnt increments. When cnt reaches DEBOUNCE_CYCLES-1 on that edge, stable <= synced and cnt <= 0.
  - If synced == stable: cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- **Key event (sticky):** evt[i] sets on the edge where stable[i] goes 0->1.
  - Cleared by a committed write to 0xC8 with wdata[i]=1 (write-1-clear).
  - If set and clear occur on the same edge, set wins.
- **Cycle counter:** cyc (32 bits) increments on every commit, wraps 0xFFFFFFFF->0, and is read-only.
- **Register map (offset : read value / write effect):**
  - 0xC0: {22'b0, sw_s} / ignored.
  - 0xC4: {(32-NKEY)'b0, stable} / ignored.
  - 0xC8: {(32-NKEY)'b0, evt} / W1C.
  - 0xCC: out_port0 / load wdata.
  - 0xD0: out_port1 / load wdata.
  - 0xD4: cyc / ignored.
- **Read path:** rdata is a pure function of addr and current register state, with no added latency. A write is visible on rdata after its commit edge.
- **Reset (resetn low, asynchronous):**
  - Cleared to 0: out_port0, out_port1, evt, cyc, all synchroniser flops, stable, cnt.
  - Takes effect immediately, mid-cycle included.
  - On the first edges after release, the synchronisers refill. A key held through reset is debounced afresh and does raise evt once it is accepted.
- **cpu_clk stuck:** cpu_clk stuck high gives no commits. cpu_clk stuck low commits every main_clk edge; this is legal and writes are idempotent.

Test Plan:
- **Reset/idle:** assert resetn=0 mid-run with out_port0=0x5 -> outputs and rdata@0xCC go to 0 immediately; after release, cyc counts 1, 2, 3 per CPU cycle (read @0xD4).
- **Single write:** we=1, addr=0xCC, wdata=0xDEADBEEF held for one CPU cycle -> out_port0=0xDEADBEEF after the cpu_clk-low edge; exactly one commit (cyc +1); out_port1 unchanged.
- **Debounce (DEBOUNCE_CYCLES=4):**
  - key_n[0] low for 3 cycles then high -> stable stays 0, evt=0.
  - key_n[0] low held -> stable[0]=1 after 2+4 edges, evt@0xC8=0x1.
- **W1C race:** evt[1]=1; commit write 0xC8 wdata=0x2 on the same edge as a new key1 press is accepted -> evt[1] stays 1. A write on a later edge with no press -> 0.
- **Decode/wrap:**
  - Write to addr=0x100000CC -> ignored.
  - Read addr=0xE0 -> 0.
  - Force cyc=0xFFFFFFFF, one commit -> cyc=0.
- **Switch sync:** sw=0x2AA -> rdata@0xC0 = 0x2AA two edges later.
